// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Moore-style control FSM for a multicycle MIPS datapath. Sequences one
//   instruction at a time through fetch, decode, execute, memory and
//   writeback. Drives every datapath select and write enable from the current
//   state, op/funct and the ALU zero flag. Stalls on a shared instruction/data
//   memory through a mem_req/mem_ready handshake. Unsupported instructions
//   park the FSM in TRAP until reset.
//
// Parameters
//   SUPPORT_JUMP : 1 decodes op 000010 (j) as JUMP, 0 treats it as illegal
//   CNT_W        : width of the retired-instruction counter
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-low reset
//   op, funct    : instruction fields from the instruction register
//   zero         : ALU zero flag, used for beq
//   mem_ready    : memory completes the current access this cycle
//   mem_req      : memory access request
//   iord         : memory address select (0 PC, 1 ALU_out)
//   mem_write    : data memory write enable
//   ir_write     : instruction register load
//   reg_dst      : write register select (0 rt, 1 rd)
//   mem_to_reg   : writeback select (0 ALU_out, 1 read data)
//   reg_write    : register file write enable
//   alu_src_a    : ALU source A select (0 PC, 1 reg A)
//   alu_src_b    : ALU source B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_control  : ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   pc_src       : next-PC select (00 ALU result, 01 ALU_out, 10 jump)
//   pc_en        : PC load enable
//   illegal_op   : high while trapped
//   state        : current state encoding, for debug
//   instr_count  : number of retired instructions
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit SUPPORT_JUMP = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    state_t w_next;
    logic   w_retire;
    logic   w_memReq;
    logic   w_memWrite;
    logic   w_irWrite;
    logic   w_regWrite;
    logic   w_pcWrite;
    logic   w_branch;

    // State register; reset lands in FETCH immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter; wraps naturally at its full width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (w_retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state and Moore output decode. Write enables are produced raw here
    // and gated by reset below.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_memReq    = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_pcWrite   = 1'b0;
        w_branch    = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        illegal_op  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memReq  = 1'b1;
                alu_src_b = 2'b01;
                w_irWrite = mem_ready;
                w_pcWrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        case (funct)
                            6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010: w_next = S_EXEC;
                            default:              w_next = S_TRAP;
                        endcase
                    end
                    OP_BEQ:  w_next = S_BRANCH;
                    OP_ADDI: w_next = S_ADDIEX;
                    OP_J:    w_next = SUPPORT_JUMP ? S_JUMP : S_TRAP;
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_MEMRD: begin
                w_memReq = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                w_memReq   = 1'b1;
                iord       = 1'b1;
                w_memWrite = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                w_branch    = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regWrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                w_pcWrite = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            default: begin
                // TRAP and any unused encoding hold until reset.
                illegal_op = 1'b1;
                w_next     = S_TRAP;
            end
        endcase
    end

    // Gating with rst keeps every enable low for the whole reset window,
    // including the instant reset arrives mid-instruction.
    assign mem_req   = w_memReq & rst;
    assign mem_write = w_memWrite & rst;
    assign ir_write  = w_irWrite & rst;
    assign reg_write = w_regWrite & rst;
    assign pc_en     = (w_pcWrite | (w_branch & zero)) & rst;
    assign state     = r_state;

endmodule
